// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared VGA timing and cursor constants, used by the sync generator and the
// cursor overlay alike, plus the coordinate clamp helper.
//   VGA_H_RES / VGA_V_RES : visible pixels per line / lines per frame
//   VGA_CUR_W / VGA_CUR_H : cursor bitmap width / height
//   VGA_CURSOR_RGB        : colour painted on cursor pixels
//   VGA_RGB_BLACK         : colour driven outside the visible area
package mouse_cursor_overlay_pkg;

  localparam int         VGA_H_RES      = 640;
  localparam int         VGA_V_RES      = 480;
  localparam int         VGA_CUR_W      = 8;
  localparam int         VGA_CUR_H      = 11;
  localparam logic [7:0] VGA_CURSOR_RGB = 8'hFF;
  localparam logic [7:0] VGA_RGB_BLACK  = 8'h00;

  // Saturate a mouse coordinate at the last visible column/row.
  function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_cursor_overlay_pos.sv
// Cursor position holder. New mouse coordinates are clamped into a pending
// register; the active position used for drawing only moves on frame_start so
// a frame is never painted from two different positions.
//   clk, rst_n            : pixel clock, async active-low reset
//   frame_start           : start-of-vblank pulse, commits pending -> active
//   mouse_x/mouse_y       : raw coordinates from the mouse decoder
//   mouse_valid           : strobe qualifying mouse_x/mouse_y
//   act_x/act_y           : position used by the drawing pipeline
module mouse_cursor_overlay_pos
  import mouse_cursor_overlay_pkg::*;
#(
  parameter int H_RES = VGA_H_RES,
  parameter int V_RES = VGA_V_RES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_valid,
  output logic [9:0] act_x,
  output logic [9:0] act_y
);

  logic [9:0] pend_x;
  logic [9:0] pend_y;
  logic [9:0] new_x;
  logic [9:0] new_y;

  assign new_x = clamp_pos(mouse_x, 10'(H_RES - 1));
  assign new_y = clamp_pos(mouse_y, 10'(V_RES - 1));

  // Pending/active position registers; a coincident strobe bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x <= 10'd0;
      pend_y <= 10'd0;
      act_x  <= 10'd0;
      act_y  <= 10'd0;
    end else begin
      if (mouse_valid) begin
        pend_x <= new_x;
        pend_y <= new_y;
      end
      if (frame_start) begin
        act_x <= mouse_valid ? new_x : pend_x;
        act_y <= mouse_valid ? new_y : pend_y;
      end
    end
  end

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Two-stage mouse cursor overlay on a VGA pixel stream. Stage 1 forms the
// pixel offset from the cursor origin and addresses the external bitmap ROM
// (mouse_painter, owned by the parent); stage 2 picks cursor or background.
//   clk, rst_n              : pixel clock, async active-low reset
//   pixel_x/pixel_y         : scan position from the sync generator
//   video_on, frame_start   : visible-area flag, start-of-vblank pulse
//   mouse_x/y, mouse_valid  : new cursor position and its strobe
//   cursor_en               : show the cursor
//   bg_rgb                  : background colour aligned with pixel_x/y
//   line_number / line_code : ROM row address out / row bits back in
//   rgb_out, cursor_hit     : final colour (2-cycle latency), cursor flag
module mouse_cursor_overlay
  import mouse_cursor_overlay_pkg::*;
#(
  parameter int         H_RES      = VGA_H_RES,
  parameter int         V_RES      = VGA_V_RES,
  parameter logic [7:0] CURSOR_RGB = VGA_CURSOR_RGB,
  parameter int         CUR_W      = VGA_CUR_W,
  parameter int         CUR_H      = VGA_CUR_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_valid,
  input  logic       cursor_en,
  input  logic [7:0] bg_rgb,
  output logic [4:0] line_number,
  input  logic [7:0] line_code,
  output logic [7:0] rgb_out,
  output logic       cursor_hit
);

  logic [9:0]  act_x;
  logic [9:0]  act_y;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;

  // Stage-1 registers. Only the offset bits that address the bitmap are kept;
  // the sign/range test has already been folded into s1_in_box.
  logic [2:0]  s1_dx;
  logic [4:0]  s1_dy;
  logic        s1_in_box;
  logic [7:0]  s1_bg;
  logic        s1_video_on;
  logic        s1_cursor_en;
  logic        hit;

  mouse_cursor_overlay_pos #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_valid(mouse_valid),
    .act_x      (act_x),
    .act_y      (act_y)
  );

  // Zero-extended subtraction: bit 10 set means the pixel is left of / above
  // the cursor, so negative offsets never alias into the box.
  assign dx     = {1'b0, pixel_x} - {1'b0, act_x};
  assign dy     = {1'b0, pixel_y} - {1'b0, act_y};
  assign in_box = !dx[10] && (dx < 11'(CUR_W)) && !dy[10] && (dy < 11'(CUR_H));

  // Stage 1: offset, box test and the video attributes travelling with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dx        <= 3'd0;
      s1_dy        <= 5'd0;
      s1_in_box    <= 1'b0;
      s1_bg        <= 8'h00;
      s1_video_on  <= 1'b0;
      s1_cursor_en <= 1'b0;
    end else begin
      s1_dx        <= dx[2:0];
      s1_dy        <= dy[4:0];
      s1_in_box    <= in_box;
      s1_bg        <= bg_rgb;
      s1_video_on  <= video_on;
      s1_cursor_en <= cursor_en;
    end
  end

  // ROM row is parked at 0 outside the box so the ROM address is quiet.
  assign line_number = s1_in_box ? s1_dy : 5'd0;
  assign hit         = s1_in_box & s1_video_on & s1_cursor_en & line_code[s1_dx];

  // Stage 2: final colour select, registered together with the hit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out    <= VGA_RGB_BLACK;
      cursor_hit <= 1'b0;
    end else begin
      cursor_hit <= hit;
      rgb_out    <= hit ? CURSOR_RGB : (s1_video_on ? s1_bg : VGA_RGB_BLACK);
    end
  end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Scoreboard bench for mouse_cursor_overlay. The bench plays the parent role:
// it supplies the cursor bitmap ROM and models the overlay at pixel level.
module tb_mouse_cursor_overlay;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam int CW = 8;
  localparam int CH = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       video_on = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] mouse_x = 10'd0;
  logic [9:0] mouse_y = 10'd0;
  logic       mouse_valid = 1'b0;
  logic       cursor_en = 1'b0;
  logic [7:0] bg_rgb = 8'h00;
  logic [4:0] line_number;
  logic [7:0] line_code;
  logic [7:0] rgb_out;
  logic       cursor_hit;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Arrow bitmap: bit n of a row is cursor column n.
  function automatic logic [7:0] bitmap_row(input int r);
    case (r)
      0: return 8'h01;  1: return 8'h03;  2: return 8'h07;  3: return 8'h0F;
      4: return 8'h1F;  5: return 8'h3F;  6: return 8'h7F;  7: return 8'hFF;
      8: return 8'h37;  9: return 8'h61; 10: return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  assign line_code = bitmap_row(int'(line_number));

  mouse_cursor_overlay dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .mouse_valid(mouse_valid), .cursor_en(cursor_en),
    .bg_rgb(bg_rgb), .line_number(line_number), .line_code(line_code),
    .rgb_out(rgb_out), .cursor_hit(cursor_hit)
  );

  // Reference model state: cursor position as the spec describes it.
  int m_pend_x = 0, m_pend_y = 0, m_act_x = 0, m_act_y = 0;

  typedef struct { logic [7:0] rgb; logic hit; } out_t;
  out_t       out_q[$];
  logic [4:0] ln_q[$];
  logic       issued = 1'b0;
  logic [1:0] pipe_v = 2'b00;

  // Issue one pixel (plus optional mouse/frame events) and predict its result.
  task automatic apply(input int px, input int py, input bit vo, input bit en,
                       input int bg, input bit mv, input int mx, input int my,
                       input bit fs);
    int dx, dy, cx, cy;
    bit inbox, h;
    logic [7:0] row;
    out_t e;
    pixel_x = 10'(px); pixel_y = 10'(py); video_on = vo; cursor_en = en;
    bg_rgb = 8'(bg); mouse_valid = mv; mouse_x = 10'(mx); mouse_y = 10'(my);
    frame_start = fs;
    dx = px - m_act_x;
    dy = py - m_act_y;
    inbox = (dx >= 0) && (dx < CW) && (dy >= 0) && (dy < CH);
    row = bitmap_row(dy);
    h = inbox && vo && en && row[dx & 7];
    e.hit = h;
    e.rgb = h ? 8'hFF : (vo ? 8'(bg) : 8'h00);
    out_q.push_back(e);
    ln_q.push_back(inbox ? 5'(dy) : 5'd0);
    cx = (mx > HR - 1) ? HR - 1 : mx;
    cy = (my > VR - 1) ? VR - 1 : my;
    if (fs) begin
      m_act_x = mv ? cx : m_pend_x;
      m_act_y = mv ? cy : m_pend_y;
    end
    if (mv) begin
      m_pend_x = cx;
      m_pend_y = cy;
    end
    issued = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    issued = 1'b0; mouse_valid = 1'b0; frame_start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec += 3;
    if (rgb_out !== 8'h00) begin
      n_err++; $display("FAIL %s rgb_out got %h want 00", tag, rgb_out);
    end
    if (cursor_hit !== 1'b0) begin
      n_err++; $display("FAIL %s cursor_hit got %b want 0", tag, cursor_hit);
    end
    if (line_number !== 5'd0) begin
      n_err++; $display("FAIL %s line_number got %0d want 0", tag, line_number);
    end
  endtask

  // Track which cycles carry a scored pixel through the 2-stage pipe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_v <= 2'b00;
    else        pipe_v <= {pipe_v[0], issued};
  end

  // Monitor: pop and compare whenever a scored pixel reaches a stage.
  always @(negedge clk) begin
    out_t e;
    logic [4:0] el;
    if (rst_n && pipe_v[0]) begin
      n_vec++;
      if (ln_q.size() == 0) begin
        n_err++; $display("FAIL line_number underflow got %0d want none", line_number);
      end else begin
        el = ln_q.pop_front();
        if (line_number !== el) begin
          n_err++; $display("FAIL line_number got %0d want %0d", line_number, el);
        end
      end
    end
    if (rst_n && pipe_v[1]) begin
      n_vec++;
      if (out_q.size() == 0) begin
        n_err++; $display("FAIL output underflow got rgb %h want none", rgb_out);
      end else begin
        e = out_q.pop_front();
        if (rgb_out !== e.rgb || cursor_hit !== e.hit) begin
          n_err++;
          $display("FAIL pixel got rgb %h hit %b want rgb %h hit %b",
                   rgb_out, cursor_hit, e.rgb, e.hit);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Cursor at origin after reset.
    apply(0, 0, 1, 1, 8'h3C, 0, 0, 0, 0);
    apply(1, 0, 1, 1, 8'h5A, 0, 0, 0, 0);

    // Move to (100,50) and commit on frame_start.
    apply(10, 10, 1, 1, 8'h11, 1, 100, 50, 0);
    apply(10, 10, 1, 1, 8'h12, 0, 0, 0, 1);
    for (int x = 100; x < 108; x++) apply(x, 57, 1, 1, 8'h20 + x, 0, 0, 0, 0);
    apply(103, 58, 1, 1, 8'h77, 0, 0, 0, 0);

    // Mid-frame move: old position until the next frame_start.
    apply(5, 5, 1, 1, 8'h33, 1, 200, 200, 0);
    for (int x = 98; x < 110; x++) apply(x, 57, 1, 1, 8'h40, 0, 0, 0, 0);
    apply(200, 200, 1, 1, 8'h44, 0, 0, 0, 0);
    apply(0, 0, 1, 1, 8'h45, 0, 0, 0, 1);
    apply(200, 200, 1, 1, 8'h46, 0, 0, 0, 0);
    apply(100, 57, 1, 1, 8'h47, 0, 0, 0, 0);

    // Clamp at the bottom-right corner with no wrap.
    apply(1, 1, 1, 1, 8'h50, 1, 700, 500, 0);
    apply(1, 1, 1, 1, 8'h51, 0, 0, 0, 1);
    apply(639, 479, 1, 1, 8'h52, 0, 0, 0, 0);
    apply(638, 479, 1, 1, 8'h53, 0, 0, 0, 0);
    apply(0, 0, 1, 1, 8'h54, 0, 0, 0, 0);
    apply(639, 0, 1, 1, 8'h55, 0, 0, 0, 0);
    apply(0, 479, 1, 1, 8'h56, 0, 0, 0, 0);
    // Cursor disabled, then blanking, on a cursor pixel.
    apply(639, 479, 1, 0, 8'h57, 0, 0, 0, 0);
    apply(639, 479, 0, 1, 8'h58, 0, 0, 0, 0);

    // Coincident strobe and frame_start take the new position at once.
    apply(0, 0, 1, 1, 8'h60, 1, 300, 100, 1);
    apply(300, 100, 1, 1, 8'h61, 0, 0, 0, 0);
    apply(639, 479, 1, 1, 8'h62, 0, 0, 0, 0);

    // Randomised pixels around the cursor with random events.
    for (int i = 0; i < 1500; i++) begin
      int px, py;
      px = m_act_x + int'($urandom_range(0, 13)) - 3;
      py = m_act_y + int'($urandom_range(0, 16)) - 3;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      apply(px, py, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
            int'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            ($urandom_range(0, 31) == 0));
    end

    // Reset pulsed mid-line while the cursor is being painted.
    apply(0, 0, 1, 1, 8'h70, 1, 50, 60, 1);
    repeat (3) apply(50, 60, 1, 1, 8'h71, 0, 0, 0, 0);
    n_vec++;
    if (rgb_out !== 8'hFF) begin
      n_err++; $display("FAIL pre_reset rgb_out got %h want ff", rgb_out);
    end
    issued = 1'b0;
    rst_n = 1'b0;
    out_q.delete();
    ln_q.delete();
    m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(0, 0, 1, 1, 8'h72, 0, 0, 0, 0);
    apply(50, 60, 1, 1, 8'h73, 0, 0, 0, 0);
    apply(2, 2, 1, 1, 8'h74, 0, 0, 0, 0);
    idle(4);

    n_vec++;
    if (out_q.size() != 0 || ln_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d/%0d pending want 0/0", out_q.size(), ln_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_overlay.md
MOUSE_CURSOR_OVERLAY -- requirements
Module: mouse_cursor_overlay

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line; pending X clamp limit.
REQ-002 Parameter V_RES, default 480, visible lines per frame; pending Y clamp limit.
REQ-003 Parameter CURSOR_RGB, default 8'hFF, colour driven on cursor pixels.
REQ-004 Parameter CUR_W, default 8, cursor width; CUR_H, default 11, cursor height.
REQ-005 Port clk, input, 1, pixel clock; the single clock of the block.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port pixel_x, input, 10, current scan column from the VGA sync generator.
REQ-008 Port pixel_y, input, 10, current scan row.
REQ-009 Port video_on, input, 1, high inside the visible area.
REQ-010 Port frame_start, input, 1, one-cycle pulse at start of vertical blanking.
REQ-011 Port mouse_x, input, 10, new cursor column from the mouse decoder.
REQ-012 Port mouse_y, input, 10, new cursor row.
REQ-013 Port mouse_valid, input, 1, one-cycle strobe qualifying mouse_x/mouse_y.
REQ-014 Port cursor_en, input, 1, high to show the cursor.
REQ-015 Port bg_rgb, input, 8, background pixel colour, aligned with pixel_x/pixel_y.
REQ-016 Port line_number, output, 5, row index to the cursor bitmap ROM.
REQ-017 Port line_code, input, 8, combinational ROM row data; bit n = cursor column n.
REQ-018 Port rgb_out, output, 8, final pixel colour.
REQ-019 Port cursor_hit, output, 1, high when rgb_out carries CURSOR_RGB.

Function
REQ-020 On mouse_valid, the block SHALL load pend_x/pend_y, clamped to H_RES-1/V_RES-1.
REQ-021 On frame_start, the block SHALL copy pend_x/pend_y into act_x/act_y, so the position changes only between frames.
REQ-022 On simultaneous mouse_valid and frame_start, act_x/act_y SHALL take the clamped new mouse values directly; pend SHALL take them too.
REQ-023 Stage 1 SHALL register dx = pixel_x - act_x and dy = pixel_y - act_y as 11-bit two's complement, plus bg_rgb, video_on and cursor_en.
REQ-024 Stage 1 SHALL flag in_box when 0 <= dx < CUR_W and 0 <= dy < CUR_H; a negative dx/dy (bit 10 set) SHALL be outside, with no wrap-around.
REQ-025 line_number SHALL equal dy[4:0] when in_box is set, else 5'd0, driven combinationally from stage-1 registers.
REQ-026 Stage 2 SHALL register hit = in_box & video_on & cursor_en & line_code[dx[2:0]].
REQ-027 rgb_out SHALL be CURSOR_RGB when hit is set, bg_rgb (stage-aligned) when video_on is set and hit is clear, and 8'h00 otherwise.
REQ-028 Latency from pixel_x/pixel_y/bg_rgb to rgb_out and cursor_hit SHALL be exactly 2 clk cycles, with one result per cycle and no stalls.
REQ-029 A cursor partially beyond the right or bottom edge SHALL be clipped; only pixels inside the box are painted.

Reset
REQ-030 While rst_n is low: pend_x, pend_y, act_x and act_y SHALL be 0; all pipeline registers SHALL be 0; rgb_out SHALL be 8'h00; cursor_hit SHALL be 0; line_number SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL clear the pipeline immediately, and output SHALL resume 2 cycles after release.

Structure
REQ-032 H_RES, V_RES, CUR_W, CUR_H and the colour constants SHALL live in a shared vga_params package/include, used by the sync generator as well.
REQ-033 The bitmap ROM SHALL stay an external sub-module (mouse_painter) instantiated by the parent, with no embedded copy.

Verification
REQ-034 Reset, then act=(0,0) and the ROM attached: pixel (0,0) -> rgb_out=8'hFF and cursor_hit=1 two cycles later; pixel (1,0) -> bg_rgb.
REQ-035 mouse (100,50) valid, then frame_start: row 57 (dy=7), x=100..107 -> all hits; row 58 (dy=8), x=103 -> bg_rgb.
REQ-036 mouse_valid mid-frame with (200,200): the current frame still paints at the old position; the next frame paints at (200,200).
REQ-037 mouse (700,500) -> clamped to (639,479); only pixel (639,479) is painted (line00 bit0); no wrap to x=0 or y=0.
REQ-038 cursor_en=0, or video_on=0 on a cursor pixel -> cursor_hit=0; rgb_out is bg_rgb or 8'h00 respectively.
REQ-039 rst_n pulsed low mid-line -> rgb_out=0 asynchronously, act=(0,0), and correct output 2 cycles after release.
